// File: rtl/mux_serializer_8b_pkg.sv
// Shared definitions for the 8-bit parallel-to-serial stage.
//   WORD_W / SEL_W      : word width and select-index width
//   state_t             : serializer FSM encoding (IDLE / SHIFT)
//   sel_first/sel_last  : start and end select index for a given bit order
package mux_serializer_8b_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit order: msb_first = 0 walks 0..7, msb_first = 1 walks 7..0.
  function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
    return msb_first ? SEL_W'(WORD_W - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
    return msb_first ? '0 : SEL_W'(WORD_W - 1);
  endfunction

endpackage

// File: rtl/mux_serializer_8b_if.sv
// Handshake bundle between a byte-wide producer, the serializer and a
// bit-serial consumer.
//   in, in_valid, in_ready       : parallel word input stream
//   y, out_valid, out_ready      : serial bit output stream
//   out_last                     : y is the final bit of the word
//   sel, busy                    : current mux select and activity flag
// master : environment side (drives in/in_valid/out_ready)
// slave  : serializer side
interface mux_serializer_8b_if;
  import mux_serializer_8b_pkg::*;

  logic [WORD_W-1:0] in;
  logic              in_valid;
  logic              in_ready;
  logic              y;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, y, out_valid, out_last, sel, busy
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, y, out_valid, out_last, sel, busy
  );

endinterface

// File: rtl/mux_8x1.sv
// 8-to-1 bit multiplexer.
//   in  : 8 data bits
//   sel : index of the bit to pass
//   y   : in[sel]
module mux_8x1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = in[sel];

endmodule

// File: rtl/mux_serializer_8b.sv
// Parallel-to-serial stage: accepts an 8-bit word on a valid/ready handshake,
// then walks a select counter over it and emits one bit per output handshake
// through mux_8x1, flagging the final bit with out_last.
//   clk  : system clock (rising edge)
//   rst  : synchronous, active-high reset
//   bus  : slave side of mux_serializer_8b_if (word in, bit stream out)
// MSB_FIRST = 0 sends bit 0 first; MSB_FIRST = 1 sends bit 7 first.
module mux_serializer_8b
  import mux_serializer_8b_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                clk,
  input logic                rst,
  mux_serializer_8b_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  data_q,  data_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;

  logic shifting;
  logic last_bit;
  logic accept;
  logic bit_fire;

  // All handshake outputs come from registered state only; in_ready is the
  // single combinational output (it must see out_ready to allow a reload on
  // the last-bit handshake with no bubble).
  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (sel_q == SEL_LAST);
  assign bit_fire = shifting && bus.out_ready;

  assign bus.in_ready  = !rst && (!shifting || (last_bit && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.out_last  = last_bit;
  assign bus.sel       = sel_q;

  // y comes only from the data register and sel, never straight from in.
  mux_8x1 u_mux (
    .in  (data_q),
    .sel (sel_q),
    .y   (bus.y)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;

    if (accept) begin
      // Covers both a load from IDLE and a reload on the last-bit handshake.
      state_d = SHIFT;
      data_d  = bus.in;
      sel_d   = SEL_FIRST;
    end else if (bit_fire) begin
      if (last_bit) begin
        state_d = IDLE;
        sel_d   = SEL_FIRST;
      end else if (MSB_FIRST) begin
        sel_d = sel_q - 3'd1;
      end else begin
        sel_d = sel_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      // NOTE: the data register is reset too, so y reads 0 out of reset
      // rather than whatever the flops powered up with.
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= SEL_FIRST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux_serializer_8b.sv
// Bench for mux_serializer_8b: one LSB-first and one MSB-first instance share
// the same stimulus. Accepted words are expanded into expected bit streams in
// per-instance queues; monitors pop and compare on every bit handshake.
module tb_mux_serializer_8b;
  import mux_serializer_8b_pkg::*;

  typedef struct packed {
    logic       y;
    logic [2:0] sel;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din       = 8'h00;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b1;

  mux_serializer_8b_if bus_l ();
  mux_serializer_8b_if bus_m ();

  assign bus_l.in        = din;
  assign bus_l.in_valid  = din_valid;
  assign bus_l.out_ready = dout_ready;
  assign bus_m.in        = din;
  assign bus_m.in_valid  = din_valid;
  assign bus_m.out_ready = dout_ready;

  mux_serializer_8b #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));
  mux_serializer_8b #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));

  int total = 0;
  int bad   = 0;

  exp_t q_l[$];
  exp_t q_m[$];

  int run_l = 0, max_run_l = 0, lasts_l = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes 8 bits in transmission order.
  task automatic push_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      q_l.push_back('{y: w[k],     sel: 3'(k),     last: (k == 7)});
      q_m.push_back('{y: w[7 - k], sel: 3'(7 - k), last: (k == 7)});
    end
  endtask

  // Monitors: compare every bit handshake against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_l.out_valid) begin
        run_l++;
        if (run_l > max_run_l) max_run_l = run_l;
      end else begin
        run_l = 0;
      end
      if (bus_l.out_valid && bus_l.out_ready) begin
        if (bus_l.out_last) lasts_l++;
        if (q_l.size() == 0) begin
          check("lsb_unexpected_bit", 1, 0);
        end else begin
          exp_t e;
          e = q_l.pop_front();
          check("lsb_y",    bus_l.y,        e.y);
          check("lsb_sel",  bus_l.sel,      e.sel);
          check("lsb_last", bus_l.out_last, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_m.out_valid && bus_m.out_ready) begin
      if (q_m.size() == 0) begin
        check("msb_unexpected_bit", 1, 0);
      end else begin
        exp_t e;
        e = q_m.pop_front();
        check("msb_y",    bus_m.y,        e.y);
        check("msb_sel",  bus_m.sel,      e.sel);
        check("msb_last", bus_m.out_last, e.last);
      end
    end
  end

  // Present a word until accepted; waits = cycles spent with in_ready low.
  // Called and returns at posedge+1.
  task automatic send_word(input logic [7:0] w, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_l.in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
    end else begin
      check("in_ready_agree", bus_m.in_ready, 1);
      push_word(w);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus_l.out_valid && !bus_m.out_valid && q_l.size() == 0 && q_m.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int  w;
  bit  rnd_run;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus_l.out_valid, 0);
    check("rst_out_last",  bus_l.out_last,  0);
    check("rst_busy",      bus_l.busy,      0);
    check("rst_y",         bus_l.y,         0);
    check("rst_sel_l",     bus_l.sel,       0);
    check("rst_sel_m",     bus_m.sel,       7);
    check("rst_in_ready",  bus_l.in_ready,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus_l.in_ready, 1);
    @(posedge clk);
    #1;

    // Single words, both bit orders, with first-bit latency of one cycle
    send_word(8'b11001100, w);
    check("idle_accept_waits", w, 0);
    @(negedge clk);
    check("latency_out_valid", bus_l.out_valid, 1);
    check("latency_busy",      bus_l.busy,      1);
    wait_idle();
    @(negedge clk);
    check("idle_in_ready", bus_l.in_ready, 1);
    check("idle_busy",     bus_l.busy,     0);
    @(posedge clk);
    #1;
    send_word(8'b00110011, w);
    wait_idle();

    // Back-to-back: second word held valid through the first
    max_run_l = 0;
    lasts_l   = 0;
    send_word(8'hCC, w);
    send_word(8'h33, w);
    check("b2b_in_ready_on_last_only", w, 7);
    wait_idle();
    check("b2b_no_gap",    max_run_l, 16);
    check("b2b_two_lasts", lasts_l,   2);

    // Backpressure: out_ready 1,0,0,1,0,0,...
    fork
      begin
        send_word(8'hA5, w);
        wait_idle();
      end
      begin
        for (int i = 0; i < 30; i++) begin
          dout_ready = (i % 3 == 0);
          @(posedge clk);
          #1;
        end
        dout_ready = 1'b1;
      end
    join

    // Reset in the middle of a word at sel=3
    send_word(8'hFF, w);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_sel", bus_l.sel, 3);
    rst = 1'b1;
    q_l.delete();
    q_m.delete();
    @(negedge clk);
    check("rst_high_in_ready", bus_l.in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_out_valid", bus_l.out_valid, 0);
    check("abort_busy",      bus_l.busy,      0);
    check("abort_sel_l",     bus_l.sel,       0);
    check("abort_sel_m",     bus_m.sel,       7);
    check("abort_in_ready",  bus_l.in_ready,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", bus_l.in_ready, 1);
    @(posedge clk);
    #1;
    send_word(8'h0F, w);
    wait_idle();

    // in_valid raised mid-word (sel=2) is held off until the last bit
    send_word(8'hAA, w);
    repeat (2) @(posedge clk);
    #1;
    send_word(8'h55, w);
    check("midword_held_off", w, 5);
    wait_idle();

    // Randomized words, gaps and backpressure
    rnd_run = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          send_word(8'($urandom), w);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        wait_idle();
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          dout_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        dout_ready = 1'b1;
      end
    join
    check("final_q_l_empty", q_l.size(), 0);
    check("final_q_m_empty", q_m.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
